alu_cmd_driver: RTL and testbench

Initiator-side front end for the team's 16-bit combinational ALU (16 modes, A/B/Cin/Mode in, Y/Cout/Overflow out).
- Accepts operation commands over a valid/ready stream and drives the ALU operand ports from registers.
- Captures the ALU outputs one cycle later and returns them over a valid/ready result stream.
- Supports chaining: the previous result can be reused as operand A, so an instruction sequencer can run multi-step arithmetic without a round trip.

---
 rtl/alu_drv_pkg.sv | 23 ++
 rtl/alu_cmd_driver_if.sv | 45 ++++
 rtl/alu_drv_stats.sv | 25 ++
 rtl/alu_cmd_driver.sv | 88 ++++++++
 tb/tb_alu_cmd_driver.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_drv_pkg.sv
// Shared definitions for the ALU command driver: ALU mode codes, the driver
// FSM state encoding and the helper that tells which modes produce valid
// carry/overflow flags.
package alu_drv_pkg;

    localparam logic [3:0] MODE_LSL = 4'd0;
    localparam logic [3:0] MODE_ADD = 4'd4;
    localparam logic [3:0] MODE_SUB = 4'd5;
    localparam logic [3:0] MODE_CMP = 4'd13;
    localparam logic [3:0] MODE_FFO = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Only the arithmetic modes drive Cout/Overflow; everything else is junk.
    function automatic logic has_flags(input logic [3:0] mode);
        return (mode == MODE_ADD) || (mode == MODE_SUB);
    endfunction

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Command stream, ALU operand/result wires and result stream of the ALU
// command driver. The slave modport is the driver, master is its environment
// (sequencer + ALU + result consumer).
interface alu_cmd_driver_if #(
    parameter int N = 16,
    parameter int M = 4
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [M-1:0] cmd_mode;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic         cmd_cin;
    logic         cmd_chain;

    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic         alu_cin;
    logic [M-1:0] alu_mode;
    logic [N-1:0] alu_y;
    logic         alu_cout;
    logic         alu_ovf;

    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_y;
    logic         res_cout;
    logic         res_ovf;
    logic [M-1:0] res_mode;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_a, cmd_b, cmd_cin, cmd_chain,
        input  alu_y, alu_cout, alu_ovf, res_ready,
        output cmd_ready, alu_a, alu_b, alu_cin, alu_mode,
        output res_valid, res_y, res_cout, res_ovf, res_mode
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_a, cmd_b, cmd_cin, cmd_chain,
        output alu_y, alu_cout, alu_ovf, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_cin, alu_mode,
        input  res_valid, res_y, res_cout, res_ovf, res_mode
    );

endinterface

// File: rtl/alu_drv_stats.sv
// Saturating operation / overflow counters for the ALU command driver.
// Only instantiated when ALU_DRV_STATS_EN is defined.
module alu_drv_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue,
    input  logic        ovf,
    output logic [15:0] stat_ops,
    output logic [15:0] stat_ovf
);

    // Count issued operations and qualified overflows, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops <= '0;
            stat_ovf <= '0;
        end else begin
            if (issue && (stat_ops != 16'hFFFF))
                stat_ops <= stat_ops + 16'd1;
            if (issue && ovf && (stat_ovf != 16'hFFFF))
                stat_ovf <= stat_ovf + 16'd1;
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// ALU command driver: registers operands for the combinational ALU, captures
// its result one cycle later and offers it on a valid/ready result stream.
// cmd_chain reuses the last captured Y as operand A.
// Optional: define ALU_DRV_STATS_EN to add stat_ops/stat_ovf counters.
module alu_cmd_driver
    import alu_drv_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_cmd_driver_if.slave   bus
`ifdef ALU_DRV_STATS_EN
    ,
    output logic [15:0]       stat_ops,
    output logic [15:0]       stat_ovf
`endif
);

    state_t       state;
    logic [N-1:0] acc;
    logic         accept;
    logic         flags_ok;

    // A new command can enter when idle, or when the held result leaves now.
    assign bus.cmd_ready = (state == IDLE) || ((state == DONE) && bus.res_ready);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign flags_ok      = has_flags(bus.alu_mode);

    // Driver FSM: load operands on accept, capture ALU output in ISSUE, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_cin   <= 1'b0;
            bus.alu_mode  <= '0;
            bus.res_valid <= 1'b0;
            bus.res_y     <= '0;
            bus.res_cout  <= 1'b0;
            bus.res_ovf   <= 1'b0;
            bus.res_mode  <= '0;
        end else begin
            if (accept) begin
                bus.alu_a    <= bus.cmd_chain ? acc : bus.cmd_a;
                bus.alu_b    <= bus.cmd_b;
                bus.alu_cin  <= bus.cmd_cin;
                bus.alu_mode <= bus.cmd_mode;
            end
            case (state)
                IDLE: begin
                    if (accept)
                        state <= ISSUE;
                end
                ISSUE: begin
                    bus.res_y     <= bus.alu_y;
                    bus.res_mode  <= bus.alu_mode;
                    acc           <= bus.alu_y;
                    bus.res_cout  <= flags_ok & bus.alu_cout;
                    bus.res_ovf   <= flags_ok & bus.alu_ovf;
                    bus.res_valid <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        state         <= accept ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_DRV_STATS_EN
    alu_drv_stats u_stats (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue    (state == ISSUE),
        .ovf      (flags_ok & bus.alu_ovf),
        .stat_ops (stat_ops),
        .stat_ovf (stat_ovf)
    );
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver with a behavioural ALU and a
// queue-based reference model of the driver's results.
module tb_alu_cmd_driver;

    typedef struct {
        logic [15:0] y;
        logic        c;
        logic        o;
        logic [3:0]  m;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    res_t        q[$];
    logic [15:0] acc_m = '0;
    int          ops_m = 0;
    int          ovf_m = 0;

    always #5 clk = ~clk;

    alu_cmd_driver_if #(.N(16), .M(4)) bus ();

`ifdef ALU_DRV_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_ovf;
    alu_cmd_driver #(.N(16), .M(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .stat_ops(stat_ops), .stat_ovf(stat_ovf)
    );
`else
    alu_cmd_driver #(.N(16), .M(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
`endif

    // Behavioural ALU: {ovf, cout, y}; non-arithmetic modes drive junk flags (1s).
    function automatic logic [17:0] alu_eval(input logic [3:0] mode, input logic [15:0] a,
                                             input logic [15:0] b, input logic cin);
        logic [16:0] s;
        logic [15:0] y;
        logic        c;
        logic        o;
        c = 1'b1;
        o = 1'b1;
        y = ~a;
        s = '0;
        case (mode)
            4'd0: y = a << b[3:0];
            4'd4: begin
                s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
                y = s[15:0];
                c = s[16];
                o = (a[15] == b[15]) && (y[15] != a[15]);
            end
            4'd5: begin
                s = {1'b0, a} + {1'b0, ~b} + {16'd0, cin};
                y = s[15:0];
                c = s[16];
                o = (a[15] != b[15]) && (y[15] != a[15]);
            end
            4'd6:  y = a & b;
            4'd7:  y = a | b;
            4'd8:  y = a ^ b;
            4'd13: y = {15'd0, ($signed(a) < $signed(b))};
            4'd15: begin
                y = 16'd16;
                for (int i = 15; i >= 0; i--)
                    if (a[i]) y = 16'(i);
            end
            default: y = ~a;
        endcase
        return {o, c, y};
    endfunction

    always_comb begin
        {bus.alu_ovf, bus.alu_cout, bus.alu_y} = alu_eval(bus.alu_mode, bus.alu_a, bus.alu_b, bus.alu_cin);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: result of one command, applied to the model accumulator.
    task automatic push_model(input logic [3:0] m, input logic [15:0] a, input logic [15:0] b,
                              input logic cin, input logic chain);
        logic [17:0] r;
        res_t        e;
        r = alu_eval(m, chain ? acc_m : a, b, cin);
        e.y = r[15:0];
        e.c = ((m == 4'd4) || (m == 4'd5)) ? r[16] : 1'b0;
        e.o = ((m == 4'd4) || (m == 4'd5)) ? r[17] : 1'b0;
        e.m = m;
        q.push_back(e);
        acc_m = r[15:0];
        ops_m++;
        if (e.o) ovf_m++;
    endtask

    task automatic set_cmd(input logic [3:0] m, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic chain);
        bus.cmd_mode  = m;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_cin   = cin;
        bus.cmd_chain = chain;
        bus.cmd_valid = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input logic [3:0] m, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic chain);
        int n;
        set_cmd(m, a, b, cin, chain);
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) chk("accept_timeout", 32'(bus.cmd_ready), 32'd1);
        push_model(m, a, b, cin, chain);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic check_head(input string tag);
        res_t e;
        if (q.size() == 0) begin
            chk({tag, "_unexpected"}, 32'(bus.res_valid), 32'd0);
        end else begin
            e = q.pop_front();
            chk({tag, "_y"},    32'(bus.res_y),    32'(e.y));
            chk({tag, "_cout"}, 32'(bus.res_cout), 32'(e.c));
            chk({tag, "_ovf"},  32'(bus.res_ovf),  32'(e.o));
            chk({tag, "_mode"}, 32'(bus.res_mode), 32'(e.m));
        end
    endtask

    // Wait (bounded) for res_valid, check against the model, step past the edge.
    task automatic wait_res(input string tag);
        int n;
        n = 0;
        while (!bus.res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
        if (bus.res_valid) check_head(tag);
        @(negedge clk);
    endtask

    logic [3:0]  bm[4];
    logic [15:0] ba[4];
    logic [15:0] bb[4];
    logic        bc[4];
    logic        bch[4];
    logic [3:0]  mode_pool[8];
    logic [15:0] y_hold;

    initial begin
        int idx;
        int got;
        int last;
        int cyc;

        mode_pool[0] = 4'd0;  mode_pool[1] = 4'd4;  mode_pool[2] = 4'd5;  mode_pool[3] = 4'd6;
        mode_pool[4] = 4'd7;  mode_pool[5] = 4'd8;  mode_pool[6] = 4'd13; mode_pool[7] = 4'd15;
        bus.cmd_valid = 1'b0;
        bus.cmd_mode  = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_cin   = 1'b0;
        bus.cmd_chain = 1'b0;
        bus.res_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_alu_a",     32'(bus.alu_a),     32'd0);
        chk("rst_alu_mode",  32'(bus.alu_mode),  32'd0);
        chk("rst_res_y",     32'(bus.res_y),     32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Overflowing add, with two-edge latency
        send(4'd4, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        chk("ovf_early_valid", 32'(bus.res_valid), 32'd0);
        chk("ovf_issue_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        chk("ovf_valid", 32'(bus.res_valid), 32'd1);
        chk("ovf_y",     32'(bus.res_y),     32'h8000);
        chk("ovf_ovf",   32'(bus.res_ovf),   32'd1);
        chk("ovf_cout",  32'(bus.res_cout),  32'd0);
        chk("ovf_mode",  32'(bus.res_mode),  32'd4);
        wait_res("ovf");

        // Chaining: (5+3) then acc+2
        send(4'd4, 16'h0005, 16'h0003, 1'b0, 1'b0);
        wait_res("ch1");
        send(4'd4, 16'hDEAD, 16'h0002, 1'b0, 1'b1);
        chk("ch2_alu_a", 32'(bus.alu_a), 32'h0008);
        @(negedge clk);
        chk("ch2_y", 32'(bus.res_y), 32'h000A);
        wait_res("ch2");

        // Flag masking after a carrying add
        send(4'd4, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        @(negedge clk);
        chk("mask1_cout", 32'(bus.res_cout), 32'd1);
        wait_res("mask1");
        send(4'd6, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0);
        @(negedge clk);
        chk("mask2_y",    32'(bus.res_y),    32'h00F0);
        chk("mask2_cout", 32'(bus.res_cout), 32'd0);
        chk("mask2_ovf",  32'(bus.res_ovf),  32'd0);
        wait_res("mask2");

        // Backpressure: held result, pending command, same-cycle accept on release
        bus.res_ready = 1'b0;
        send(4'd5, 16'h1234, 16'h0234, 1'b1, 1'b0);
        @(negedge clk);
        y_hold = bus.res_y;
        chk("bp_y_first", 32'(y_hold), 32'(q[0].y));
        set_cmd(4'd6, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("bp_valid",     32'(bus.res_valid), 32'd1);
            chk("bp_y_stable",  32'(bus.res_y),     32'(y_hold));
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.cmd_ready), 32'd1);
        check_head("bp1");
        push_model(4'd6, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("bp_issue_valid", 32'(bus.res_valid), 32'd0);
        wait_res("bp2");

        // Back-to-back traffic with random commands
        for (int i = 0; i < 4; i++) begin
            bm[i]  = mode_pool[$urandom_range(7, 0)];
            ba[i]  = 16'($urandom);
            bb[i]  = 16'($urandom);
            bc[i]  = 1'($urandom);
            bch[i] = (i == 2);
        end
        idx = 0;
        got = 0;
        last = -1;
        cyc = 0;
        while (got < 4 && cyc < 40) begin
            if (idx < 4) set_cmd(bm[idx], ba[idx], bb[idx], bc[idx], bch[idx]);
            else bus.cmd_valid = 1'b0;
            if (bus.res_valid) begin
                check_head("b2b");
                if (last >= 0) chk("b2b_gap", 32'(cyc - last), 32'd2);
                last = cyc;
                got++;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                push_model(bm[idx], ba[idx], bb[idx], bc[idx], bch[idx]);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        chk("b2b_count", 32'(got), 32'd4);

        // Random soak with random result backpressure
        for (int i = 0; i < 24; i++) begin
            bus.res_ready = 1'b0;
            send(mode_pool[$urandom_range(7, 0)], 16'($urandom), 16'($urandom),
                 1'($urandom), ($urandom_range(2, 0) == 0));
            repeat ($urandom_range(2, 0)) @(negedge clk);
            bus.res_ready = 1'b1;
            wait_res("rnd");
        end

`ifdef ALU_DRV_STATS_EN
        chk("stat_ops", 32'(stat_ops), 32'(ops_m));
        chk("stat_ovf", 32'(stat_ovf), 32'(ovf_m));
`endif

        // Reset during ISSUE drops the command and clears acc
        send(4'd4, 16'h1111, 16'h2222, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rmid_valid",     32'(bus.res_valid), 32'd0);
        chk("rmid_alu_a",     32'(bus.alu_a),     32'd0);
        chk("rmid_alu_b",     32'(bus.alu_b),     32'd0);
        chk("rmid_alu_mode",  32'(bus.alu_mode),  32'd0);
        chk("rmid_alu_cin",   32'(bus.alu_cin),   32'd0);
        chk("rmid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        q.delete();
        acc_m = '0;
        ops_m = 0;
        ovf_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rpost_valid", 32'(bus.res_valid), 32'd0);
        send(4'd4, 16'hBEEF, 16'h0001, 1'b0, 1'b1);
        @(negedge clk);
        chk("rpost_y", 32'(bus.res_y), 32'h0001);
        wait_res("rpost");
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
